// File: rtl/at_response_packer.sv
// at_response_packer
//   Collects the HC-05 reply bytes that follow an AT command and packs them
//   big-endian, two per 16-bit word, with the first byte in the high half.
//   Collection ends on a CR LF pair, on a byte that arrives with the buffer
//   full (overflow), or after an idle gap of TIMEOUT_CYCLES clocks (timeout).
//
// Ports
//   clock       system clock, rising edge active
//   resetn      asynchronous active-low reset
//   start       one-cycle pulse: clear the buffer and status, begin collecting
//   rx_byte     received byte, qualified by rx_valid
//   rx_valid    one-cycle strobe from the UART receiver
//   words       packed buffer, word i at [16i+15:16i]
//   word_count  number of words holding at least one byte
//   busy        collecting
//   done        collection finished (terminator, overflow or timeout)
//   overflow    sticky: a byte arrived with the buffer full
//   timeout     sticky: the idle limit expired
module at_response_packer #(
  parameter int unsigned WORDS          = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  output logic [16*WORDS-1:0]  words,
  output logic [4:0]           word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 timeout
);

  localparam int unsigned    TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TLAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TONE     = TW'(1);
  localparam logic [5:0]     FULL_IDX = 6'(2 * WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [16*WORDS-1:0]   words_q, words_d;
  logic [4:0]            word_count_q, word_count_d;
  logic [5:0]            idx_q, idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic                  cr_q, cr_d;

  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    word_count_d = word_count_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;
    cr_d         = cr_q;

    if (start) begin
      // start overrides a simultaneous rx_valid; that byte is discarded
      state_d      = S_COLLECT;
      words_d      = '0;
      word_count_d = '0;
      idx_d        = '0;
      timer_d      = '0;
      overflow_d   = 1'b0;
      timeout_d    = 1'b0;
      cr_d         = 1'b0;
    end else if (state_q == S_COLLECT) begin
      if (rx_valid) begin
        if (idx_q == FULL_IDX) begin
          overflow_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          // idx_q[5:1] selects the word, idx_q[0] the half (0 = high byte)
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (32'(idx_q[5:1]) == i) begin
              if (!idx_q[0]) begin
                words_d[16*i +: 16] = {rx_byte, 8'h00};
              end else begin
                words_d[16*i +: 8] = rx_byte;
              end
            end
          end
          if (!idx_q[0]) begin
            word_count_d = idx_q[5:1] + 5'd1;
          end
          idx_d   = idx_q + 6'd1;
          timer_d = '0;
          cr_d    = (rx_byte == 8'h0D);
          if (rx_byte == 8'h0A && cr_q) begin
            state_d = S_DONE;
          end
        end
      end else if (timer_q == TLAST) begin
        timeout_d = 1'b1;
        state_d   = S_DONE;
      end else begin
        timer_d = timer_q + TONE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      words_q      <= '0;
      word_count_q <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      cr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      word_count_q <= word_count_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      cr_q         <= cr_d;
    end
  end

  assign words      = words_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == S_COLLECT);
  assign done       = (state_q == S_DONE);
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule
